// File: rtl/fpu_sb_pkg.sv
// -----------------------------------------------------------------------------
// fpu_sb_pkg
// Shared types and helpers for the FPU in-flight register scoreboard.
//   SB_ADDR_MAX : storage width of a tracked destination. Register addresses
//                 narrower than this are zero-extended, so any RAW up to
//                 SB_ADDR_MAX is supported.
//   BANK_A/B    : values of the register-address MSB (bank select).
//   sb_entry_t  : one pipeline stage {valid, dest}.
//   sb_match    : true when an entry is valid and holds the given address.
// -----------------------------------------------------------------------------
package fpu_sb_pkg;

    localparam int SB_ADDR_MAX = 8;

    localparam logic BANK_A = 1'b0;
    localparam logic BANK_B = 1'b1;

    typedef struct packed {
        logic                   valid;
        logic [SB_ADDR_MAX-1:0] dest;
    } sb_entry_t;

    function automatic logic sb_match(input sb_entry_t entry,
                                      input logic [SB_ADDR_MAX-1:0] addr);
        return entry.valid && (entry.dest == addr);
    endfunction

endpackage

// File: rtl/fpu_sb_match.sv
// -----------------------------------------------------------------------------
// fpu_sb_match
// Compares one register address against every tracked pipeline stage.
// Parameters:
//   DEPTH     : number of stages in entries
//   MASK_LAST : when set, the final (writeback) stage is ignored
// Ports:
//   entries : in  all stage entries, stage k at entries[k]
//   addr    : in  address to look up (zero-extended to SB_ADDR_MAX)
//   en      : in  lookup enable; hit is 0 when low
//   hit     : out address matches at least one valid, unmasked stage
// -----------------------------------------------------------------------------
module fpu_sb_match
    import fpu_sb_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MASK_LAST = 1'b0
) (
    input  sb_entry_t [DEPTH-1:0]       entries,
    input  logic [SB_ADDR_MAX-1:0]      addr,
    input  logic                        en,
    output logic                        hit
);

    // NOTE: every signal written in an always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (en && sb_match(entries[k], addr) && !(MASK_LAST && (k == DEPTH - 1))) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fpu_scoreboard.sv
// -----------------------------------------------------------------------------
// fpu_scoreboard
// In-flight destination scoreboard for the FPU issue path. Accepted ops that
// write a register travel through a fixed DEPTH-stage shift register; the last
// stage feeds a registered writeback strobe. A new op is held off while any of
// its enabled sources (RAW) or its destination (WAW) matches a valid stage.
//
// Build option: define FPU_SB_WB_BYPASS_EN when the register file is
// write-through; a source match in the writeback stage alone then does not
// stall. Destination matches in that stage still stall.
//
// Parameters: DEPTH (>=1) stages, NUM_SRC (>=1) sources, RAW address width
//             (RAW <= SB_ADDR_MAX, MSB is the bank select).
// Ports:
//   clk_i, rst_i   : clock (rising edge), asynchronous active-high reset
//   issue_valid_i  : in  decoder presents an FPU op
//   issue_ready_o  : out op may be accepted (no hazard, no flush)
//   src_i          : in  source addresses, source n at [n*RAW +: RAW]
//   src_en_i       : in  per-source register-operand enable
//   dest_i         : in  destination address
//   dest_we_i      : in  op writes dest_i
//   flush_i        : in  kill all in-flight ops
//   hazard_o       : out RAW or WAW conflict with a valid stage (comb)
//   inflight_o     : out registered count of valid stages
//   wb_valid_o     : out registered writeback strobe
//   wb_dest_o      : out registered writeback destination
// -----------------------------------------------------------------------------
module fpu_scoreboard
    import fpu_sb_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int NUM_SRC = 2,
    parameter int RAW     = 6
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [NUM_SRC*RAW-1:0]      src_i,
    input  logic [NUM_SRC-1:0]          src_en_i,
    input  logic [RAW-1:0]              dest_i,
    input  logic                        dest_we_i,
    input  logic                        flush_i,
    output logic                        hazard_o,
    output logic [$clog2(DEPTH+1)-1:0]  inflight_o,
    output logic                        wb_valid_o,
    output logic [RAW-1:0]              wb_dest_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

`ifdef FPU_SB_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    sb_entry_t [DEPTH-1:0] stage_q;
    sb_entry_t [DEPTH-1:0] stage_d;
    logic [NUM_SRC-1:0]    raw_hit;
    logic                  waw_hit;
    logic                  accept;
    logic [CNT_W-1:0]      cnt_d;
    logic [CNT_W-1:0]      inflight_q;
    logic                  wb_valid_q;
    logic [RAW-1:0]        wb_dest_q;

    // ---------------------------------------------------------------- hazards
    for (genvar n = 0; n < NUM_SRC; n++) begin : g_raw
        fpu_sb_match #(
            .DEPTH     (DEPTH),
            .MASK_LAST (WB_BYPASS)
        ) u_raw (
            .entries (stage_q),
            .addr    (SB_ADDR_MAX'(src_i[n*RAW +: RAW])),
            .en      (src_en_i[n]),
            .hit     (raw_hit[n])
        );
    end

    fpu_sb_match #(
        .DEPTH     (DEPTH),
        .MASK_LAST (1'b0)
    ) u_waw (
        .entries (stage_q),
        .addr    (SB_ADDR_MAX'(dest_i)),
        .en      (dest_we_i),
        .hit     (waw_hit)
    );

    assign hazard_o      = (|raw_hit) || waw_hit;
    // Flush blocks issue so a redirect never lets a wrong-path op in.
    assign issue_ready_o = !hazard_o && !flush_i;
    assign accept        = issue_valid_i && issue_ready_o;

    // ------------------------------------------------------- next stage state
    always_comb begin
        stage_d = stage_q;
        // Ops with no register result never occupy a stage. Stage 0's dest
        // only changes on accept; the valid bit is what matters downstream.
        stage_d[0].valid = accept && dest_we_i;
        if (accept) begin
            stage_d[0].dest = SB_ADDR_MAX'(dest_i);
        end
        // Fixed-latency pipeline: the shift never stalls.
        for (int k = 1; k < DEPTH; k++) begin
            stage_d[k]       = stage_q[k-1];
            stage_d[k].valid = stage_q[k-1].valid && !flush_i;
        end
    end

    always_comb begin
        cnt_d = '0;
        for (int k = 0; k < DEPTH; k++) begin
            cnt_d = cnt_d + CNT_W'(stage_d[k].valid);
        end
    end

    // -------------------------------------------------------------- registers
    // NOTE: the stage entries are few and their dest fields feed the match
    // logic and wb_dest_o, so the whole array is reset, not just the valids.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage_q    <= '0;
            inflight_q <= '0;
            wb_valid_q <= 1'b0;
            wb_dest_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples
            // the pre-edge values, independent of statement order.
            stage_q    <= stage_d;
            inflight_q <= cnt_d;
            wb_valid_q <= stage_q[DEPTH-1].valid && !flush_i;
            wb_dest_q  <= stage_q[DEPTH-1].dest[RAW-1:0];
        end
    end

    assign inflight_o = inflight_q;
    assign wb_valid_o = wb_valid_q;
    assign wb_dest_o  = wb_dest_q;

endmodule
